// File: rtl/core_pkg.sv
// Shared RV32I pipeline types: ALU operation codes and the ID/EX stage register layout.
package core_pkg;

    localparam int CORE_XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_PASS = 4'd10
    } alu_op_t;

    typedef struct packed {
        logic                 valid;
        logic [CORE_XLEN-1:0] pc;
        logic [4:0]           rs1_addr;
        logic [4:0]           rs2_addr;
        logic [4:0]           rd;
        logic                 write_rd;
        logic                 wb_use_mem;
        alu_op_t              alu_op;
        logic                 use_imm;
        logic [CORE_XLEN-1:0] imm;
    } id_ex_t;

    // A bubble must never look like a producer, so write_rd and wb_use_mem stay 0.
    localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Flags a decode instruction that reads the destination of a load currently in ID/EX.
module load_use_detect
    import core_pkg::*;
(
    input  id_ex_t     id_ex,
    input  logic       id_valid,
    input  logic [4:0] rs1_addr,
    input  logic [4:0] rs2_addr,
    input  logic       rs1_used,
    input  logic       rs2_used,
    output logic       load_use
);

    logic producer_is_load;
    logic rs1_hit;
    logic rs2_hit;

    // x0 is never a real dependency, hence the rd != 0 qualifier.
    assign producer_is_load = id_ex.valid & id_ex.wb_use_mem & id_ex.write_rd & (id_ex.rd != 5'd0);
    assign rs1_hit          = rs1_used & (rs1_addr == id_ex.rd);
    assign rs2_hit          = rs2_used & (rs2_addr == id_ex.rd);
    assign load_use         = producer_is_load & id_valid & (rs1_hit | rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, forwarding operand muxes
// and refresh of held operands while Execute is frozen.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int XLEN  = CORE_XLEN,
    parameter int CNT_W = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            id_valid_i,
    input  logic [XLEN-1:0] id_pc_i,
    input  logic [4:0]      id_rs1_addr_i,
    input  logic [4:0]      id_rs2_addr_i,
    input  logic            id_rs1_used_i,
    input  logic            id_rs2_used_i,
    input  logic [XLEN-1:0] id_rs1_rdata_i,
    input  logic [XLEN-1:0] id_rs2_rdata_i,
    input  logic [XLEN-1:0] id_imm_i,
    input  logic [4:0]      id_rd_addr_i,
    input  logic            id_write_rd_i,
    input  logic            id_wb_use_mem_i,
    input  alu_op_t         id_alu_op_i,
    input  logic            id_use_imm_i,
    input  logic            hold_i,
    input  logic            flush_i,
    input  logic            fwd_ex_mem_rs1_i,
    input  logic            fwd_ex_mem_rs2_i,
    input  logic            fwd_mem_wb_rs1_i,
    input  logic            fwd_mem_wb_rs2_i,
    input  logic [XLEN-1:0] fwd_ex_mem_data_i,
    input  logic [XLEN-1:0] fwd_mem_wb_data_i,
    output id_ex_t          id_ex_o,
    output logic [XLEN-1:0] operand_a_o,
    output logic [XLEN-1:0] operand_b_o,
    output logic            stall_id_o,
    output logic [CNT_W-1:0] bubble_count_o
);

    id_ex_t          id_ex_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic            load_use;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    id_ex_t          id_capture;

    load_use_detect u_load_use_detect (
        .id_ex    (id_ex_q),
        .id_valid (id_valid_i),
        .rs1_addr (id_rs1_addr_i),
        .rs2_addr (id_rs2_addr_i),
        .rs1_used (id_rs1_used_i),
        .rs2_used (id_rs2_used_i),
        .load_use (load_use)
    );

    assign stall_id_o = !flush_i & (hold_i | load_use);

    // EX/MEM is the younger producer, so it takes precedence over MEM/WB.
    always_comb begin
        rs1_fwd = rs1_data_q;
        if (fwd_ex_mem_rs1_i)
            rs1_fwd = fwd_ex_mem_data_i;
        else if (fwd_mem_wb_rs1_i)
            rs1_fwd = fwd_mem_wb_data_i;

        rs2_fwd = rs2_data_q;
        if (fwd_ex_mem_rs2_i)
            rs2_fwd = fwd_ex_mem_data_i;
        else if (fwd_mem_wb_rs2_i)
            rs2_fwd = fwd_mem_wb_data_i;
    end

    always_comb begin
        id_capture            = ID_EX_BUBBLE;
        id_capture.valid      = id_valid_i;
        id_capture.pc         = id_pc_i;
        id_capture.rs1_addr   = id_rs1_addr_i;
        id_capture.rs2_addr   = id_rs2_addr_i;
        id_capture.rd         = id_rd_addr_i;
        id_capture.write_rd   = id_write_rd_i;
        id_capture.wb_use_mem = id_wb_use_mem_i;
        id_capture.alu_op     = id_alu_op_i;
        id_capture.use_imm    = id_use_imm_i;
        id_capture.imm        = id_imm_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            id_ex_q      <= ID_EX_BUBBLE;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            bubble_cnt_q <= '0;
        end else if (flush_i) begin
            id_ex_q <= ID_EX_BUBBLE;
        end else if (hold_i) begin
            // A forwarding source may retire during the hold; latch it while it is visible.
            if (fwd_ex_mem_rs1_i | fwd_mem_wb_rs1_i)
                rs1_data_q <= rs1_fwd;
            if (fwd_ex_mem_rs2_i | fwd_mem_wb_rs2_i)
                rs2_data_q <= rs2_fwd;
        end else if (load_use) begin
            id_ex_q <= ID_EX_BUBBLE;
            if (bubble_cnt_q != {CNT_W{1'b1}})
                bubble_cnt_q <= bubble_cnt_q + 1'b1;
        end else begin
            id_ex_q    <= id_capture;
            rs1_data_q <= id_rs1_rdata_i;
            rs2_data_q <= id_rs2_rdata_i;
        end
    end

    assign id_ex_o        = id_ex_q;
    assign operand_a_o    = rs1_fwd;
    assign operand_b_o    = id_ex_q.use_imm ? id_ex_q.imm : rs2_fwd;
    assign bubble_count_o = bubble_cnt_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between Decode and Execute in the 5-stage RV32I core.
- Latches decoded fields, detects load-use hazards and inserts a one-cycle bubble.
- Applies the forwarding-unit select flags and data to produce the final Execute operands.
- Refreshes held operands so that forwarded values are not lost while Execute is frozen.

Parameters:
XLEN, 32, datapath width
CNT_W, 16, width of the load-use bubble counter

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
id_valid_i  in  1  decode holds a valid instruction
id_pc_i  in  XLEN  decode PC
id_rs1_addr_i / id_rs2_addr_i  in  5  source register indices
id_rs1_used_i / id_rs2_used_i  in  1  instruction actually reads rs1/rs2
id_rs1_rdata_i / id_rs2_rdata_i  in  XLEN  register-file read data (write-first regfile)
id_imm_i  in  XLEN  decoded immediate
id_rd_addr_i  in  5  destination index
id_write_rd_i  in  1  writes rd
id_wb_use_mem_i  in  1  instruction is a load
id_alu_op_i  in  alu_op_t  ALU operation
id_use_imm_i  in  1  operand B is the immediate
hold_i  in  1  Execute busy; freeze ID/EX
flush_i  in  1  branch/jump redirect; squash
fwd_ex_mem_rs1_i / fwd_ex_mem_rs2_i  in  1  forward flags from EX/MEM
fwd_mem_wb_rs1_i / fwd_mem_wb_rs2_i  in  1  forward flags from MEM/WB
fwd_ex_mem_data_i / fwd_mem_wb_data_i  in  XLEN  forwarded data
id_ex_o  out  id_ex_t  registered stage contents (valid, pc, rs1/rs2 addr, rd, write_rd, wb_use_mem, alu_op, use_imm, imm)
operand_a_o / operand_b_o  out  XLEN  forwarded operands to the ALU (B = imm if use_imm)
stall_id_o  out  1  IF/ID must hold this cycle
bubble_count_o  out  CNT_W  saturating count of load-use bubbles

Behaviour:
- Reset (asynchronous, rst_i=1): all id_ex_o fields 0, valid 0, stored rs data 0, bubble_count_o 0. Outputs are driven from reset values immediately, not on the next edge.
- load_use = id_ex.valid & id_ex.wb_use_mem & id_ex.write_rd & id_ex.rd!=0 & id_valid_i & ((id_rs1_used_i & rs1==rd) | (id_rs2_used_i & rs2==rd)).
- stall_id_o = !flush_i & (hold_i | load_use). Purely combinational.
- Per-edge priority:
  - 1) flush_i: load a bubble (valid=0, write_rd=0, wb_use_mem=0; other fields don't-care).
  - 2) hold_i: keep all fields. Refresh stored rs1/rs2 data: if a forward flag for that operand is set, capture the muxed forwarded value.
  - 3) load_use: load a bubble; bubble_count +1, saturating at all-ones.
  - 4) otherwise: capture decode fields; valid = id_valid_i.
- Bubble invariant: any bubble must have write_rd=0 and wb_use_mem=0, so it never triggers forwarding or a stall.
- Operand mux, per operand: EX/MEM flag first, then MEM/WB flag, otherwise stored data. Latency 0 from the flags.
- operand_b_o = imm when use_imm, else the forwarded rs2 value.
- Counter behaviour:
  - hold_i together with load_use: no bubble, no count; re-evaluated when hold drops.
  - flush_i together with load_use: flush wins; no count.
  - No wrap-around past saturation.
- Decode-side hazard: when a capture happens (priority 4) and the previous ID/EX instruction writes the same rd, nothing extra is needed; the forwarding unit handles it next cycle.

Decomposition:
- Shared package core_pkg holds:
  - alu_op_t enum
  - id_ex_t packed struct
  - ID_EX_BUBBLE constant (valid/write_rd/wb_use_mem all 0)
- One combinational sub-module, load_use_detect, computes load_use from id_ex_t and the decode fields. The register, mux and counter stay in id_ex_stage.

Test Plan:
- Normal advance: id_valid=1, rs1=5, rs1_rdata=0x11, no flags → next cycle id_ex_o.valid=1, rs1_addr=5, operand_a_o=0x11.
- Load-use: ID/EX holds lw x3 (rd=3, wb_use_mem=1); decode add x4,x3,x1 with rs1_used → stall_id_o=1 that cycle. Next cycle valid=0, write_rd=0, bubble_count_o=1. The following cycle captures the add.
- x0/unused source: lw x0 followed by an x0 reader, or a matching rs2 with rs2_used=0 → stall_id_o=0, no bubble, count unchanged.
- Forward priority: fwd_ex_mem_rs1=1 with 0xAAAA and fwd_mem_wb_rs1=1 with 0xBBBB → operand_a_o=0xAAAA. Clear ex_mem → 0xBBBB. Clear both → stored data.
- Hold refresh: hold_i for 2 cycles; cycle 1 fwd_mem_wb_rs2=1 with 0x1234, cycle 2 flags 0 → operand_b_o=0x1234 after the hold, use_imm=0.
- Flush corners:
  - flush_i with load_use → stall_id_o=0, bubble, count unchanged.
  - flush_i with hold_i → bubble.
  - rst_i mid-hold → valid=0 and count=0 without a clock edge.
